// File: rtl/uart_dump_tx.sv
// Streams a block of 32-bit RAM words out of an 8N1 UART, MSB byte first.
// One word is fetched, latched, then shifted as four back-to-back frames.
module uart_dump_tx #(
    parameter int BAUD_DIV = 868,
    parameter int ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   wordCount,
    output logic [ADDR_W-1:0] memAddr,
    input  logic [31:0]       memData,
    output logic              uartTx,
    output logic              busy,
    output logic              done
);
    // state  | meaning
    // IDLE   | line high, waiting for start
    // FETCH  | memAddr presented to RAM
    // WAIT   | RAM read latency; word captured at the end of this cycle
    // SHIFT  | four frames of the latched word on the line
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, SHIFT} state_t;

    localparam logic [15:0]     BAUD_LOAD = 16'(BAUD_DIV - 1);
    localparam logic [3:0]      STOP_BIT  = 4'd9;
    localparam logic [ADDR_W:0] ONE_WORD  = (ADDR_W + 1)'(1);

    state_t            state, state_nx;
    logic [15:0]       baud_cnt, baud_cnt_nx;
    logic [3:0]        bit_idx, bit_idx_nx;
    logic [1:0]        byte_idx, byte_idx_nx;
    logic [31:0]       word_reg, word_nx;
    logic [ADDR_W:0]   words_left, words_left_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              tx_nx, busy_nx, done_nx;

    logic [7:0] cur_byte;
    logic [3:0] bit_inc;
    logic [2:0] data_sel;
    logic       next_bit_val;

    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte = word_reg[31:24];
            2'd1:    cur_byte = word_reg[23:16];
            2'd2:    cur_byte = word_reg[15:8];
            default: cur_byte = word_reg[7:0];
        endcase
    end

    // Frame slot 0 is the start bit, slots 1..8 carry data LSB first, slot 9 is stop.
    assign bit_inc      = bit_idx + 4'd1;
    assign data_sel     = bit_inc[2:0] - 3'd1;
    assign next_bit_val = (bit_inc == STOP_BIT) ? 1'b1 : cur_byte[data_sel];

    always_comb begin
        state_nx      = state;
        baud_cnt_nx   = baud_cnt;
        bit_idx_nx    = bit_idx;
        byte_idx_nx   = byte_idx;
        word_nx       = word_reg;
        words_left_nx = words_left;
        addr_nx       = memAddr;
        tx_nx         = uartTx;
        busy_nx       = busy;
        done_nx       = 1'b0;

        case (state)
            IDLE: begin
                tx_nx = 1'b1;
                if (start) begin
                    if (wordCount == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        words_left_nx = wordCount;
                        addr_nx       = '0;
                        busy_nx       = 1'b1;
                        state_nx      = FETCH;
                    end
                end
            end
            FETCH: begin
                state_nx = WAIT;
            end
            WAIT: begin
                word_nx     = memData;
                tx_nx       = 1'b0;
                bit_idx_nx  = '0;
                byte_idx_nx = '0;
                baud_cnt_nx = BAUD_LOAD;
                state_nx    = SHIFT;
            end
            SHIFT: begin
                if (baud_cnt != '0) begin
                    baud_cnt_nx = baud_cnt - 16'd1;
                end else if (bit_idx != STOP_BIT) begin
                    bit_idx_nx  = bit_inc;
                    tx_nx       = next_bit_val;
                    baud_cnt_nx = BAUD_LOAD;
                end else if (byte_idx != 2'd3) begin
                    byte_idx_nx = byte_idx + 2'd1;
                    bit_idx_nx  = '0;
                    tx_nx       = 1'b0;
                    baud_cnt_nx = BAUD_LOAD;
                end else if (words_left == ONE_WORD) begin
                    // Decide on the remaining count, not on memAddr, so a full-space dump cannot wrap.
                    words_left_nx = '0;
                    tx_nx         = 1'b1;
                    busy_nx       = 1'b0;
                    done_nx       = 1'b1;
                    state_nx      = IDLE;
                end else begin
                    words_left_nx = words_left - ONE_WORD;
                    addr_nx       = memAddr + 1'b1;
                    tx_nx         = 1'b1;
                    state_nx      = FETCH;
                end
            end
            default: begin
                state_nx = IDLE;
                tx_nx    = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            word_reg   <= '0;
            words_left <= '0;
            memAddr    <= '0;
            uartTx     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            baud_cnt   <= baud_cnt_nx;
            bit_idx    <= bit_idx_nx;
            byte_idx   <= byte_idx_nx;
            word_reg   <= word_nx;
            words_left <= words_left_nx;
            memAddr    <= addr_nx;
            uartTx     <= tx_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end
endmodule
